// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: opcodes, forwarding selects, destination slot.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package riscv_pkg;

  localparam int RF_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight producer: destination register and what it does with it.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } slot_t;

  // A slot only produces a value for src if it really writes a non-x0 register.
  function automatic logic slot_hit(input slot_t s, input logic [RF_ADDR_W-1:0] src);
    return s.reg_write && (s.rd != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/src_use_decode.sv
// Decodes which register sources an instruction in ID actually reads.
// Latency: purely combinational.
// Backpressure: none; output follows the opcode.
module src_use_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  // Only U-type and JAL lack rs1; only R-type, stores and branches read rs2.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1 = 1'b0;
      default:                     uses_rs1 = 1'b1;
    endcase
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, branch flush, EX operand forwarding.
// Latency: controls combinational same cycle; shadow slots and stall counter update on clk.
// Backpressure: stall holds PC/IF-ID; branch_taken overrides stall. HAZARD_FORWARD_EN enables forwarding.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            if_id_instruction,
  input  logic                   if_id_valid,
  input  logic [REG_ADDR_W-1:0]  id_ex_rs1,
  input  logic [REG_ADDR_W-1:0]  id_ex_rs2,
  input  logic [REG_ADDR_W-1:0]  id_ex_rd,
  input  logic                   id_ex_reg_write,
  input  logic                   id_ex_mem_read,
  input  logic                   branch_taken,
  output logic                   stall,
  output logic                   bubble,
  output logic                   flush_if_id,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [REG_ADDR_W-1:0]  w_id_rs1;
  logic [REG_ADDR_W-1:0]  w_id_rs2;
  logic                   w_uses_rs1;
  logic                   w_uses_rs2;
  logic                   w_load_use;
  logic                   w_stall_req;
  logic [1:0]             w_fwd_a;
  logic [1:0]             w_fwd_b;
  slot_t                  w_ex_slot;
  slot_t                  r_mem_slot;
  slot_t                  r_wb_slot;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_unused_instr;

  assign w_id_rs1       = if_id_instruction[15 +: REG_ADDR_W];
  assign w_id_rs2       = if_id_instruction[20 +: REG_ADDR_W];
  assign w_unused_instr = ^{if_id_instruction[31:25], if_id_instruction[14:7]};

  src_use_decode u_src_use_decode (
    .opcode   (if_id_instruction[6:0]),
    .uses_rs1 (w_uses_rs1),
    .uses_rs2 (w_uses_rs2)
  );

  assign w_ex_slot.rd        = id_ex_rd;
  assign w_ex_slot.reg_write = id_ex_reg_write;
  assign w_ex_slot.mem_read  = id_ex_mem_read;

  // A load in EX cannot forward to ID's consumer in time; reg_write is not
  // consulted here, only that the load targets a real register.
  assign w_load_use = if_id_valid && id_ex_mem_read && (id_ex_rd != '0) &&
                      ((w_uses_rs1 && (w_id_rs1 == id_ex_rd)) ||
                       (w_uses_rs2 && (w_id_rs2 == id_ex_rd)));

`ifdef HAZARD_FORWARD_EN
  // MEM is checked first so the youngest producer wins a double hit.
  assign w_fwd_a = slot_hit(r_mem_slot, id_ex_rs1) ? FWD_MEM :
                   slot_hit(r_wb_slot,  id_ex_rs1) ? FWD_WB  : FWD_RF;
  assign w_fwd_b = slot_hit(r_mem_slot, id_ex_rs2) ? FWD_MEM :
                   slot_hit(r_wb_slot,  id_ex_rs2) ? FWD_WB  : FWD_RF;
  assign w_stall_req = w_load_use;
`else
  // No bypass network: any in-flight producer of a used source must drain
  // through writeback before ID may proceed.
  logic w_raw_rs1;
  logic w_raw_rs2;
  logic w_unused_ex_src;

  assign w_raw_rs1 = w_uses_rs1 && (slot_hit(w_ex_slot,  w_id_rs1) ||
                                    slot_hit(r_mem_slot, w_id_rs1) ||
                                    slot_hit(r_wb_slot,  w_id_rs1));
  assign w_raw_rs2 = w_uses_rs2 && (slot_hit(w_ex_slot,  w_id_rs2) ||
                                    slot_hit(r_mem_slot, w_id_rs2) ||
                                    slot_hit(r_wb_slot,  w_id_rs2));
  assign w_stall_req     = w_load_use || (if_id_valid && (w_raw_rs1 || w_raw_rs2));
  assign w_fwd_a         = FWD_RF;
  assign w_fwd_b         = FWD_RF;
  assign w_unused_ex_src = ^{id_ex_rs1, id_ex_rs2};
`endif

  // Output priority: reset silences everything, a taken branch flushes the
  // wrong-path ID instruction instead of stalling it, else honour stall request.
  always_comb begin
    stall       = 1'b0;
    bubble      = 1'b0;
    flush_if_id = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (!rst) begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      if (branch_taken) begin
        flush_if_id = 1'b1;
        bubble      = 1'b1;
      end else if (w_stall_req) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  // Shadow the EX producer as it advances into MEM and then WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_slot <= '0;
      r_wb_slot  <= '0;
    end else begin
      r_mem_slot <= w_ex_slot;
      r_wb_slot  <= r_mem_slot;
    end
  end

  // Count stalled cycles, sticking at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table plus multi-cycle sequences.
// Latency: checks sampled on the falling edge, inputs driven just after rising edge.
// Backpressure: n/a; expectations switch on HAZARD_FORWARD_EN.
module tb_hazard_unit;
  import riscv_pkg::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic        id_ex_reg_write, id_ex_mem_read, branch_taken;
  logic        stall, bubble, flush_if_id;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .id_ex_rs1         (id_ex_rs1),
    .id_ex_rs2         (id_ex_rs2),
    .id_ex_rd          (id_ex_rd),
    .id_ex_reg_write   (id_ex_reg_write),
    .id_ex_mem_read    (id_ex_mem_read),
    .branch_taken      (branch_taken),
    .stall             (stall),
    .bubble            (bubble),
    .flush_if_id       (flush_if_id),
    .fwd_a             (fwd_a),
    .fwd_b             (fwd_b),
    .stall_count       (stall_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        rw, mr, br;
    logic        stall_f, stall_n, flush;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_ex_rs1 = rs1; id_ex_rs2 = rs2; id_ex_rd = rd;
    id_ex_reg_write = rw; id_ex_mem_read = mr;
  endtask

  task automatic set_id(input logic [31:0] instr, input logic vld);
    if_id_instruction = instr; if_id_valid = vld;
  endtask

  task automatic do_reset();
    rst = 1'b1; branch_taken = 1'b0;
    set_ex(0, 0, 0, 0, 0);
    set_id(32'h0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic b, input logic f);
    chk({tag, "_stall"},  {31'b0, stall},       {31'b0, s});
    chk({tag, "_bubble"}, {31'b0, bubble},      {31'b0, b});
    chk({tag, "_flush"},  {31'b0, flush_if_id}, {31'b0, f});
  endtask

  initial begin
    logic es;
    logic [31:0] add_dep;
    add_dep = enc(OPC_OP, 5'd6, 5'd5, 5'd7);

    // instr, vld, ex_rs1, ex_rs2, ex_rd, rw, mr, br, stall(fwd), stall(nofwd), flush
    vecs[0]  = '{add_dep,                       1, 1, 2, 5, 1, 1, 0, 1, 1, 0};
    vecs[1]  = '{enc(OPC_OP,    6, 7, 5),       1, 1, 2, 5, 1, 1, 0, 1, 1, 0};
    vecs[2]  = '{enc(OPC_STORE, 0, 8, 5),       1, 1, 2, 5, 1, 1, 0, 1, 1, 0};
    vecs[3]  = '{enc(OPC_OP_IMM,6, 7, 5),       1, 1, 2, 5, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{enc(OPC_LUI,   9, 9, 9),       1, 1, 2, 9, 1, 1, 0, 0, 0, 0};
    vecs[5]  = '{enc(OPC_OP,    6, 0, 0),       1, 1, 2, 0, 1, 1, 0, 0, 0, 0};
    vecs[6]  = '{add_dep,                       0, 1, 2, 5, 1, 1, 0, 0, 0, 0};
    vecs[7]  = '{add_dep,                       1, 1, 2, 5, 1, 1, 1, 0, 0, 1};
    vecs[8]  = '{enc(OPC_OP,    5, 4, 1),       1, 1, 2, 4, 1, 0, 0, 0, 1, 0};
    vecs[9]  = '{enc(OPC_BRANCH,0, 6, 5),       1, 1, 2, 5, 1, 1, 0, 1, 1, 0};
    vecs[10] = '{enc(OPC_JAL,   1, 5, 5),       1, 1, 2, 5, 1, 1, 0, 0, 0, 0};
    vecs[11] = '{add_dep,                       1, 1, 2, 5, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{enc(OPC_JALR,  1, 5, 0),       1, 1, 2, 5, 1, 1, 0, 1, 1, 0};
    vecs[13] = '{enc(OPC_LOAD,  8, 5, 0),       1, 1, 2, 5, 1, 1, 0, 1, 1, 0};
    vecs[14] = '{enc(OPC_AUIPC, 3, 5, 5),       1, 1, 2, 5, 1, 1, 0, 0, 0, 0};
    vecs[15] = '{enc(OPC_OP_IMM,7, 4, 0),       1, 1, 2, 4, 1, 0, 1, 0, 0, 1};

    // Reset state: outputs held low while rst is high, counter cleared after.
    rst = 1'b1; branch_taken = 1'b0;
    set_ex(5, 5, 5, 1, 1);
    set_id(add_dep, 1'b1);
    tick(); tick();
    @(negedge clk);
    chk_ctl("rst_hold", 0, 0, 0);
    chk("rst_fwd_a", {30'b0, fwd_a}, 32'd0);
    chk("rst_count", {16'b0, stall_count}, 32'd0);

    // Single-cycle vectors, each from empty slots.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      set_id(vecs[i].instr, vecs[i].vld);
      set_ex(vecs[i].ex_rs1, vecs[i].ex_rs2, vecs[i].ex_rd, vecs[i].rw, vecs[i].mr);
      branch_taken = vecs[i].br;
      @(negedge clk);
      es = FWD_EN ? vecs[i].stall_f : vecs[i].stall_n;
      chk_ctl($sformatf("v%0d", i), es, es | vecs[i].flush, vecs[i].flush);
      chk($sformatf("v%0d_fwd_a", i), {30'b0, fwd_a}, 32'd0);
      chk($sformatf("v%0d_fwd_b", i), {30'b0, fwd_b}, 32'd0);
      tick();
    end

    // Load-use: one stall, then consumer in EX forwards from MEM, then WB.
    do_reset();
    set_ex(5, 0, 5, 1, 1); set_id(add_dep, 1'b1);
    @(negedge clk); chk_ctl("lu_c0", 1, 1, 0);
    tick();
    set_ex(5, 7, 6, 1, 0); set_id(32'h0, 1'b0);
    @(negedge clk);
    chk_ctl("lu_c1", 0, 0, 0);
    chk("lu_c1_fwd_a", {30'b0, fwd_a}, FWD_EN ? 32'd1 : 32'd0);
    chk("lu_c1_fwd_b", {30'b0, fwd_b}, 32'd0);
    chk("lu_c1_count", {16'b0, stall_count}, 32'd1);
    tick();
    set_ex(5, 7, 0, 0, 0);
    @(negedge clk);
    chk("lu_c2_fwd_a", {30'b0, fwd_a}, FWD_EN ? 32'd2 : 32'd0);
    chk("lu_c2_fwd_b", {30'b0, fwd_b}, 32'd0);
    tick();

    // Double hit: MEM and WB both hold x3, MEM wins; then only WB.
    do_reset();
    set_ex(0, 0, 3, 1, 0); tick(); tick();
    set_ex(0, 3, 0, 0, 0);
    @(negedge clk);
    chk("dh_both_fwd_b", {30'b0, fwd_b}, FWD_EN ? 32'd1 : 32'd0);
    chk("dh_both_fwd_a", {30'b0, fwd_a}, 32'd0);
    tick();
    @(negedge clk);
    chk("dh_wb_fwd_b", {30'b0, fwd_b}, FWD_EN ? 32'd2 : 32'd0);
    tick();

    // Load to x0 never stalls or forwards.
    do_reset();
    set_ex(0, 0, 0, 1, 1); set_id(enc(OPC_OP, 6, 0, 0), 1'b1);
    @(negedge clk); chk_ctl("x0_c0", 0, 0, 0);
    tick();
    set_ex(0, 0, 0, 0, 0); set_id(32'h0, 1'b0);
    @(negedge clk);
    chk("x0_fwd_a", {30'b0, fwd_a}, 32'd0);
    chk("x0_fwd_b", {30'b0, fwd_b}, 32'd0);
    tick();

    // Branch override leaves the counter untouched.
    do_reset();
    set_ex(5, 0, 5, 1, 1); set_id(add_dep, 1'b1);
    @(negedge clk); chk_ctl("br_c0", 1, 1, 0);
    tick();
    branch_taken = 1'b1;
    @(negedge clk);
    chk_ctl("br_c1", 0, 1, 1);
    chk("br_c1_count", {16'b0, stall_count}, 32'd1);
    tick();
    branch_taken = 1'b0; set_ex(0, 0, 0, 0, 0); set_id(32'h0, 1'b0);
    @(negedge clk);
    chk("br_c2_count", {16'b0, stall_count}, 32'd1);
    tick();

    // Reset mid-stall: outputs drop immediately, state clears at the edge.
    do_reset();
    set_ex(5, 0, 5, 1, 1); set_id(add_dep, 1'b1);
    @(negedge clk); chk_ctl("rs_c0", 1, 1, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_ctl("rs_c1", 0, 0, 0);
    chk("rs_c1_fwd_a", {30'b0, fwd_a}, 32'd0);
    chk("rs_c1_count", {16'b0, stall_count}, 32'd1);
    tick();
    rst = 1'b0; set_ex(5, 5, 0, 0, 0); set_id(32'h0, 1'b0);
    @(negedge clk);
    chk("rs_c2_fwd_a", {30'b0, fwd_a}, 32'd0);
    chk("rs_c2_fwd_b", {30'b0, fwd_b}, 32'd0);
    chk("rs_c2_count", {16'b0, stall_count}, 32'd0);
    tick();

    // ALU producer then dependent add: three stalls without bypass, none with.
    do_reset();
    set_ex(1, 0, 4, 1, 0); set_id(enc(OPC_OP, 5, 4, 1), 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      es = (FWD_EN || c == 3) ? 1'b0 : 1'b1;
      chk_ctl($sformatf("raw_c%0d", c), es, es, 0);
      chk($sformatf("raw_c%0d_fwd_a", c), {30'b0, fwd_a}, 32'd0);
      chk($sformatf("raw_c%0d_fwd_b", c), {30'b0, fwd_b}, 32'd0);
      tick();
      set_ex(0, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("raw_count", {16'b0, stall_count}, FWD_EN ? 32'd0 : 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that consumes the ID/EX stage register contents (rs1/rs2/rd plus decode control bits) and the IF/ID instruction. It generates stall, bubble and flush controls for the front end and operand-forwarding selects for EX. It keeps its own shadow copy of the MEM and WB destination slots, so it is the downstream reader of everything the ID/EX register publishes.

## Interface
- `REG_ADDR_W`, 5: register-index width.
- `STALL_CNT_W`, 16: width of the stall performance counter.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `if_id_instruction` in 32: instruction currently in ID.
- `if_id_valid` in 1: ID holds a real instruction.
- `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd` in `REG_ADDR_W`: fields held in the ID/EX register.
- `id_ex_reg_write` in 1: EX instruction writes rd.
- `id_ex_mem_read` in 1: EX instruction is a load.
- `branch_taken` in 1: EX resolved a taken branch or jump this cycle.
- `stall` out 1: hold PC and IF/ID.
- `bubble` out 1: load NOP controls into ID/EX at the next edge.
- `flush_if_id` out 1: clear IF/ID at the next edge.
- `fwd_a`, `fwd_b` out 2: EX operand source. 00 = regfile, 01 = MEM slot, 10 = WB slot.
- `stall_count` out `STALL_CNT_W`: saturating count of stall cycles.

## Operation
- **ID source use** is decoded from `if_id_instruction[6:0]`:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH only.
  - Unused sources never cause a stall.
- **Shadow slots.** Each edge loads `mem_slot <= {id_ex_rd, id_ex_reg_write, id_ex_mem_read}`, then `wb_slot <= mem_slot`. A slot with rd = 0 or reg_write = 0 never matches.
- **Forwarding.** Applies to each EX source (`id_ex_rs1` drives `fwd_a`, `id_ex_rs2` drives `fwd_b`).
  - A MEM-slot match selects 01.
  - Otherwise a WB-slot match selects 10.
  - Otherwise 00.
  - When MEM and WB both match, MEM wins (youngest producer).
- **Load-use.** `stall = bubble = 1` when `id_ex_mem_read`, `id_ex_rd != 0`, and id_ex_rd equals a used ID source with `if_id_valid`.
- **Control flush.** `branch_taken` forces `flush_if_id = bubble = 1` and `stall = 0`, overriding any stall request, because the ID instruction is wrong-path.
- **Stall counter.** `stall_count` increments on every edge where `stall = 1`. It saturates at all-ones.
- **Reset.**
  - Slots are cleared and `stall_count` is 0.
  - While `rst` is high, `stall`, `bubble`, `flush_if_id`, `fwd_a` and `fwd_b` are forced to 0.
  - Reset asserted mid-stall drops the stall on that same cycle.

## Timing
- `stall`, `bubble`, `flush_if_id` and `fwd_*` are combinational from the current inputs and slots, and are valid in the same cycle.
- Slots and the counter update on the rising edge of `clk`.
- Load-use costs exactly one stall cycle. After the edge, the load sits in `mem_slot`, ID/EX holds a bubble, and the dependent instruction is forwarded from MEM on the following cycle.
- Back-to-back loads feeding a dependent instruction: each dependency is evaluated independently, with at most 1 stall per load.
- The regfile is not write-through, so a WB-slot match still forwards (10).

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - Behaviour is as above.
- `HAZARD_FORWARD_EN` undefined:
  - `fwd_a` and `fwd_b` are tied to 00.
  - `stall = bubble = 1` whenever a used ID source matches the EX producer (`id_ex_rd` with `id_ex_reg_write`), `mem_slot` or `wb_slot`.
  - A dependency on EX therefore stalls 3 cycles, MEM 2 cycles and WB 1 cycle.
  - `branch_taken` priority is unchanged.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - Forwarding-select constants: `FWD_RF`, `FWD_MEM`, `FWD_WB`.
  - The slot struct: rd, reg_write, mem_read.
- Sub-module `src_use_decode` is combinational: opcode in, `uses_rs1` and `uses_rs2` out, instantiated once.
- Slots, compare logic and counter live in `hazard_unit`.

## Test plan
- **Load-use stall.** EX holds a load with rd = x5 (`id_ex_mem_read = 1`, `id_ex_reg_write = 1`). ID holds `add x6, x5, x7`.
  - Cycle 0: `stall = bubble = 1`.
  - Next cycle: `stall = 0`. With EX now holding the add (rs1 = x5), `fwd_a = 01`.
- **Double-hit priority.** `mem_slot` rd = x3 and `wb_slot` rd = x3, EX rs2 = x3 -> `fwd_b = 01`. After mem_slot is cleared -> `fwd_b = 10`.
- **x0 and unused sources.**
  - Load to x0 followed by an add reading x0 -> no stall, `fwd = 00`.
  - `lui x9` in ID while EX holds a load to x9 -> no stall.
- **Branch override.** Load-use condition and `branch_taken = 1` in the same cycle -> `stall = 0`, `flush_if_id = 1`, `bubble = 1`, and `stall_count` unchanged.
- **Reset mid-stall.** Assert `rst` while `stall = 1` -> outputs are 0 that cycle. After the edge, slots are cleared and `stall_count = 0`.
- **Without `HAZARD_FORWARD_EN`.** `addi x4` in EX (`id_ex_reg_write = 1`, `id_ex_mem_read = 0`), dependent `add` reading x4 in ID -> `stall = 1` for exactly 3 cycles, `stall_count = 3`, `fwd_a = fwd_b = 00` throughout.
